// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the unified-memory arbiter: FSM state
// encodings, owner encodings, default geometry and the round-robin pick.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_WORDS  = 8;
   localparam int DEF_WB     = $clog2(DEF_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Round-robin pick: on a tie the requester that did not go last wins,
   // otherwise whichever one is asking.
   function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                         input owner_e last_owner);
      if (i_req && d_req)
         return (last_owner == OWN_I) ? OWN_D : OWN_I;
      else if (d_req)
         return OWN_D;
      else
         return OWN_I;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side handshakes and the memory-side bus around the
// arbiter. The arbiter uses the slave view; caches and memory use master.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int WORDS  = DEF_WORDS
) ();
   localparam int WB = $clog2(WORDS);

   // I-cache fill port
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [WB-1:0]     i_rword;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;

   // D-cache fill / write port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [WB-1:0]     d_rword;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;

   // Memory bus
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
      output i_gnt, i_rvalid, i_rword, i_rdata, i_done,
             d_gnt, d_rvalid, d_rword, d_rdata, d_done,
             mem_en, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
      input  i_gnt, i_rvalid, i_rword, i_rdata, i_done,
             d_gnt, d_rvalid, d_rword, d_rdata, d_done,
             mem_en, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arb_fill_ctr.sv
// Issue and receive counters for one block fill. Both are one bit wider
// than the word index so "all issued" is just the top bit; they clear
// together when a fill starts.
module mem_arb_fill_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int WORDS = DEF_WORDS,
   localparam int WB   = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,      // entering FILL: clear both counters
   input  logic          issue_en,   // in FILL: advance issue while words remain
   input  logic          recv_en,    // a memory word for the owner arrived
   output logic [WB-1:0] ic_idx,
   output logic [WB-1:0] rc_idx,
   output logic          ic_live,    // more addresses to issue
   output logic          last_word   // next arriving word is the final one
);
   localparam logic [WB:0] CNT_ONE  = (WB+1)'(1);
   localparam logic [WB:0] CNT_LAST = (WB+1)'(WORDS - 1);

   logic [WB:0] ic_q, ic_d;
   logic [WB:0] rc_q, rc_d;

   assign ic_live   = ~ic_q[WB];
   assign last_word = (rc_q == CNT_LAST);
   assign ic_idx    = ic_q[WB-1:0];
   assign rc_idx    = rc_q[WB-1:0];

   // Next-count logic: clear on start, else step independently.
   always_comb begin
      ic_d = ic_q;
      rc_d = rc_q;
      if (start) begin
         ic_d = '0;
         rc_d = '0;
      end else begin
         if (issue_en && ic_live)
            ic_d = ic_q + CNT_ONE;
         if (recv_en && !rc_q[WB])
            rc_d = rc_q + CNT_ONE;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ic_q <= '0;
         rc_q <= '0;
      end else begin
         ic_q <= ic_d;
         rc_q <= rc_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported main memory between I-cache fills and D-cache
// fills/writes. Round-robin on ties, pipelined 8-word fills with one address
// per cycle, and return data routed to the current owner with its word index.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int WORDS  = DEF_WORDS
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int WB = $clog2(WORDS);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_owner_q, last_owner_d;
   owner_e            grant_own;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
   logic              i_done_q, i_done_d, d_done_q, d_done_d;

   logic              fill_start;
   logic              in_fill, in_write, fill_issue, recv;
   logic              ic_live, last_word;
   logic [WB-1:0]     ic_idx, rc_idx;

   assign in_fill    = (state_q == ST_FILL);
   assign in_write   = (state_q == ST_WRITE);
   assign fill_issue = in_fill && ic_live;
   // Returns outside FILL (including stale ones after a reset) are dropped.
   assign recv       = in_fill && bus.mem_rvalid;

   mem_arb_fill_ctr #(.WORDS(WORDS)) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .start     (fill_start),
      .issue_en  (in_fill),
      .recv_en   (recv),
      .ic_idx    (ic_idx),
      .rc_idx    (rc_idx),
      .ic_live   (ic_live),
      .last_word (last_word)
   );

   // Arbitration and sequencing: next state, capture on grant, gnt/done pulses.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      base_d       = base_q;
      wdata_d      = wdata_q;
      i_gnt_d      = 1'b0;
      d_gnt_d      = 1'b0;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      fill_start   = 1'b0;
      grant_own    = pick_owner(bus.i_req, bus.d_req, last_owner_q);
      case (state_q)
         ST_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               owner_d      = grant_own;
               last_owner_d = grant_own;
               if (grant_own == OWN_D) begin
                  base_d  = bus.d_addr;
                  wdata_d = bus.d_wdata;
                  d_gnt_d = 1'b1;
                  if (bus.d_we) begin
                     state_d = ST_WRITE;
                  end else begin
                     state_d    = ST_FILL;
                     fill_start = 1'b1;
                  end
               end else begin
                  base_d     = bus.i_addr;
                  i_gnt_d    = 1'b1;
                  state_d    = ST_FILL;
                  fill_start = 1'b1;
               end
            end
         end
         ST_FILL: begin
            if (recv && last_word) begin
               state_d  = ST_DONE;
               i_done_d = (owner_q == OWN_I);
               d_done_d = (owner_q == OWN_D);
            end
         end
         ST_WRITE: begin
            state_d  = ST_DONE;
            i_done_d = (owner_q == OWN_I);
            d_done_d = (owner_q == OWN_D);
         end
         default: begin
            // DONE: one cycle, requests ignored.
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, captured request and registered handshake pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_I;
         base_q       <= '0;
         wdata_q      <= '0;
         i_gnt_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         base_q       <= base_d;
         wdata_q      <= wdata_d;
         i_gnt_q      <= i_gnt_d;
         d_gnt_q      <= d_gnt_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
      end
   end

   // Memory bus: fill reads walk the block from word 0, a write is one beat.
   // Address and data are forced to zero when no access is issued.
   assign bus.mem_en    = fill_issue || in_write;
   assign bus.mem_wr    = in_write;
   assign bus.mem_addr  = in_write   ? base_q :
                          fill_issue ? {base_q[ADDR_W-1:WB], ic_idx} : '0;
   assign bus.mem_wdata = in_write ? wdata_q : '0;

   // Return routing: only the owner sees data; everything else reads zero.
   assign bus.i_gnt    = i_gnt_q;
   assign bus.d_gnt    = d_gnt_q;
   assign bus.i_done   = i_done_q;
   assign bus.d_done   = d_done_q;
   assign bus.i_rvalid = recv && (owner_q == OWN_I);
   assign bus.d_rvalid = recv && (owner_q == OWN_D);
   assign bus.i_rword  = bus.i_rvalid ? rc_idx : '0;
   assign bus.d_rword  = bus.d_rvalid ? rc_idx : '0;
   assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
   assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-L in-order memory model with an
// optional random return gap, plus hand-timed fill/write/arbitration cases.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int lat     = 4;
   bit gap_en  = 1'b0;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } rsp_t;
   rsp_t rq[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A5A;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: reads issued in cycle c return in cycle c+lat (or later with gaps), in order.
   initial begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = '0;
         if (rq.size() > 0 && rq[0].due <= cyc && !(gap_en && $urandom_range(0, 2) == 0)) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mdata(rq[0].addr);
            void'(rq.pop_front());
         end
         @(negedge clk);
         if (bus.mem_en && !bus.mem_wr)
            rq.push_back('{addr: bus.mem_addr, due: cyc + lat});
      end
   end

   task automatic chk_idle_outs(input string tag);
      chk({tag, " ctl"}, 32'({bus.i_gnt, bus.i_rvalid, bus.i_done, bus.d_gnt,
                              bus.d_rvalid, bus.d_done, bus.mem_en, bus.mem_wr}), 32'(0));
      chk({tag, " bus"}, {bus.mem_addr, bus.mem_wdata}, 32'(0));
      chk({tag, " rdata"}, {bus.i_rdata, bus.d_rdata}, 32'(0));
      chk({tag, " rword"}, 32'({bus.i_rword, bus.d_rword}), 32'(0));
   endtask

   // One block fill from I (use_d=0) or D (use_d=1) requested in cycle T.
   task automatic fill_txn(input string tag, input bit use_d, input logic [15:0] addr,
                           input int l, input bit gap);
      int t0, n_iss, n_wd, gnt_c, done_c, last_c, bad;
      logic gnt, rv, dn, o_bad;
      logic [2:0]  rw;
      logic [15:0] rd, ea;
      lat    = l;
      gap_en = gap;
      @(posedge clk); #1;
      t0 = cyc;
      if (use_d) begin
         bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addr;
      end else begin
         bus.i_req = 1'b1; bus.i_addr = addr;
      end
      n_iss = 0; n_wd = 0; gnt_c = -1; done_c = -1; last_c = -1; bad = 0;
      for (int k = 0; k < 80 && done_c < 0; k++) begin
         @(negedge clk);
         gnt = use_d ? bus.d_gnt    : bus.i_gnt;
         rv  = use_d ? bus.d_rvalid : bus.i_rvalid;
         dn  = use_d ? bus.d_done   : bus.i_done;
         rw  = use_d ? bus.d_rword  : bus.i_rword;
         rd  = use_d ? bus.d_rdata  : bus.i_rdata;
         o_bad = use_d ? (bus.i_gnt | bus.i_rvalid | bus.i_done | (|bus.i_rdata) | (|bus.i_rword))
                       : (bus.d_gnt | bus.d_rvalid | bus.d_done | (|bus.d_rdata) | (|bus.d_rword));
         if (o_bad || (!rv && (rd != 16'h0 || rw != 3'h0))) bad++;
         if (gnt) gnt_c = cyc;
         if (bus.mem_en) begin
            ea = {addr[15:3], 3'(n_iss)};
            chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(ea));
            chk({tag, " mem_wr"}, 32'(bus.mem_wr), 32'(0));
            chk({tag, " issue_cyc"}, 32'(cyc), 32'(t0 + 1 + n_iss));
            n_iss++;
         end
         if (rv) begin
            ea = {addr[15:3], 3'(n_wd)};
            chk({tag, " rword"}, 32'(rw), 32'(n_wd));
            chk({tag, " rdata"}, 32'(rd), 32'(mdata(ea)));
            if (!gap) chk({tag, " word_cyc"}, 32'(cyc), 32'(t0 + 1 + l + n_wd));
            last_c = cyc;
            n_wd++;
         end
         if (dn) done_c = cyc;
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      gap_en    = 1'b0;
      chk({tag, " gnt_cyc"}, 32'(gnt_c), 32'(t0 + 1));
      chk({tag, " n_issue"}, 32'(n_iss), 32'(8));
      chk({tag, " n_words"}, 32'(n_wd), 32'(8));
      chk({tag, " done_after_last"}, 32'(done_c), 32'(last_c + 1));
      if (!gap) chk({tag, " done_cyc"}, 32'(done_c - t0), 32'(9 + l));
      chk({tag, " stray_outputs"}, 32'(bad), 32'(0));
      $display("[TB] %s: fill %s addr=0x%04h L=%0d words=%0d done@T+%0d",
               tag, use_d ? "D" : "I", addr, l, n_wd, done_c - t0);
   endtask

   // Single-word D write requested in cycle T; six cycles observed.
   task automatic write_txn(input string tag, input logic [15:0] addr, input logic [15:0] data);
      int t0, n_en, gnt_c, done_c, bad;
      @(posedge clk); #1;
      t0 = cyc;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = addr; bus.d_wdata = data;
      n_en = 0; gnt_c = -1; done_c = -1; bad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.mem_en) begin
            chk({tag, " en_cyc"}, 32'(cyc), 32'(t0 + 1));
            chk({tag, " mem_wr"}, 32'(bus.mem_wr), 32'(1));
            chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(addr));
            chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'(data));
            n_en++;
         end
         if (bus.d_gnt) gnt_c = cyc;
         if (bus.d_done) begin
            done_c = cyc;
            bus.d_req = 1'b0; bus.d_we = 1'b0;
         end
         if (bus.i_gnt | bus.i_rvalid | bus.i_done | bus.d_rvalid | (|bus.d_rdata)) bad++;
      end
      bus.d_req = 1'b0; bus.d_we = 1'b0;
      chk({tag, " gnt_cyc"}, 32'(gnt_c), 32'(t0 + 1));
      chk({tag, " done_cyc"}, 32'(done_c), 32'(t0 + 2));
      chk({tag, " n_mem_en"}, 32'(n_en), 32'(1));
      chk({tag, " stray_outputs"}, 32'(bad), 32'(0));
      $display("[TB] %s: write addr=0x%04h data=0x%04h done@T+%0d", tag, addr, data, done_c - t0);
   endtask

   // Both requesters raise fills in cycle T; n transactions, grants must go D, I, D, I.
   task automatic both_txns(input string tag, input int n, input bit drop,
                            input logic [15:0] ia, input logic [15:0] da);
      int   t0, ng, nd;
      int   gc[4];
      int   dc[4];
      logic who[4];
      lat = 4;
      @(posedge clk); #1;
      t0 = cyc;
      bus.i_req = 1'b1; bus.i_addr = ia;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = da;
      ng = 0; nd = 0;
      for (int j = 0; j < 4; j++) begin gc[j] = -1; dc[j] = -1; who[j] = 1'b0; end
      for (int k = 0; k < 200 && nd < n; k++) begin
         @(negedge clk);
         if (bus.d_gnt && ng < 4) begin who[ng] = 1'b1; gc[ng] = cyc; ng++; end
         if (bus.i_gnt && ng < 4) begin who[ng] = 1'b0; gc[ng] = cyc; ng++; end
         if (bus.d_done || bus.i_done) begin
            if (nd < 4) dc[nd] = cyc;
            nd++;
            if (drop) begin
               if (bus.d_done) bus.d_req = 1'b0;
               else            bus.i_req = 1'b0;
            end
         end
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      chk({tag, " n_grants"}, 32'(ng), 32'(n));
      chk({tag, " n_dones"}, 32'(nd), 32'(n));
      chk({tag, " first_gnt_cyc"}, 32'(gc[0]), 32'(t0 + 1));
      for (int j = 0; j < n && j < 4; j++) begin
         chk({tag, $sformatf(" owner%0d_is_d", j)}, 32'(who[j]), 32'(j % 2 == 0));
         chk({tag, $sformatf(" fill%0d_len", j)}, 32'(dc[j] - gc[j]), 32'(12));
         if (j > 0) chk({tag, $sformatf(" gnt%0d_cyc", j)}, 32'(gc[j]), 32'(dc[j-1] + 2));
      end
      $display("[TB] %s: %0d shared transactions, first owner %s, grants %0d", tag, n,
               who[0] ? "D" : "I", ng);
   endtask

   initial begin
      int n_wd, stale, leak;
      rst = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(negedge clk);
      chk_idle_outs("reset");
      rst = 1'b0;
      $display("[TB] reset released");

      // Tie right after reset: D first, then I; then four alternating grants.
      both_txns("t2 tie", 2, 1'b1, 16'h0800, 16'h0400);
      both_txns("t4 rr", 4, 1'b0, 16'h1100, 16'h2200);

      fill_txn("t1 ifill", 1'b0, 16'h1235, 4, 1'b0);
      write_txn("t3 write", 16'h0040, 16'hBEEF);

      // Reset in the middle of an I fill, once the third word has arrived.
      // At that point 7 reads are issued and 4 returns are still in flight.
      lat = 4;
      @(posedge clk); #1;
      bus.i_req = 1'b1; bus.i_addr = 16'h5550;
      n_wd = 0;
      for (int k = 0; k < 40 && n_wd < 3; k++) begin
         @(negedge clk);
         if (bus.i_rvalid) n_wd++;
      end
      #1 rst = 1'b1;
      #1;
      chk_idle_outs("t5 in_reset");
      chk("t5 pending_returns", 32'(rq.size()), 32'(4));
      bus.i_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      stale = 0; leak = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.mem_rvalid) stale++;
         if (bus.i_rvalid | bus.d_rvalid | bus.mem_en | bus.i_done | bus.d_done | bus.i_gnt) leak++;
      end
      chk("t5 stale_returns", 32'(stale), 32'(4));
      chk("t5 stale_leak", 32'(leak), 32'(0));
      $display("[TB] t5 reset: stale returns=%0d routed=%0d", stale, leak);
      fill_txn("t5 refill", 1'b0, 16'h2468, 4, 1'b0);

      // Memory latency corners and a gappy return stream.
      fill_txn("t6 L1", 1'b1, 16'h0A13, 1, 1'b0);
      fill_txn("t6 L7", 1'b0, 16'h7FF8, 7, 1'b0);
      fill_txn("t6 gap", 1'b1, 16'h3338, 4, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
